// File: rtl/ext_mem_bridge_pkg.sv
// Shared types and constants for the external SRAM bridge: FSM states,
// bus polarities and strobe bundle.
package ext_mem_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } bridge_state_t;

  // mem_rw polarity of the core
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // SRAM strobes are active low
  localparam logic STROBE_ON  = 1'b0;
  localparam logic STROBE_OFF = 1'b1;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } strobe_t;

  localparam strobe_t STROBE_IDLE = '{
    ce_n:    STROBE_OFF,
    oe_n:    STROBE_OFF,
    we_n:    STROBE_OFF,
    data_oe: 1'b0
  };

  // Counter width able to hold wait_cycles, never narrower than one bit.
  function automatic int cnt_width(input int wait_cycles);
    if (wait_cycles < 2) begin
      return 1;
    end
    return $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/ext_mem_bridge_if.sv
// Core-side request bus and SRAM-side pad bus of the bridge, plus the FSM
// state as a debug view.
interface ext_mem_bridge_if #(
  parameter int DATA_W = 8
);
  import ext_mem_bridge_pkg::*;

  // Handshake: core_req is the valid; it is sampled only while the bridge is
  // idle, must be held until core_ready, and core_ready is a one-cycle pulse
  // marking completion (read data is valid on core_rdata from that cycle on).
  logic              core_req;
  logic              core_rw;
  logic [7:0]        core_addr_h;
  logic [7:0]        core_addr_l;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_ready;
  logic              busy;

  logic [15:0]       ext_addr;
  logic [DATA_W-1:0] ext_data_o;
  logic              ext_data_oe;
  logic [DATA_W-1:0] ext_data_i;
  logic              ext_ce_n;
  logic              ext_oe_n;
  logic              ext_we_n;

  bridge_state_t     dbg_state;

  modport slave (
    input  core_req, core_rw, core_addr_h, core_addr_l, core_wdata,
    input  ext_data_i,
    output core_rdata, core_ready, busy,
    output ext_addr, ext_data_o, ext_data_oe, ext_ce_n, ext_oe_n, ext_we_n,
    output dbg_state
  );

  modport master (
    output core_req, core_rw, core_addr_h, core_addr_l, core_wdata,
    output ext_data_i,
    input  core_rdata, core_ready, busy,
    input  ext_addr, ext_data_o, ext_data_oe, ext_ce_n, ext_oe_n, ext_we_n,
    input  dbg_state
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the ACCESS phase; expired_o is registered and
// high in the final ACCESS cycle.
module mem_wait_counter
  import ext_mem_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             expired_q;
  logic             expired_d;

  always_comb begin
    cnt_d     = cnt_q;
    expired_d = expired_q;
    if (load_i) begin
      cnt_d     = LOAD_VAL;
      expired_d = (LOAD_VAL == '0);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d     = cnt_q - CNT_W'(1);
      // Flag goes high together with the counter reaching zero.
      expired_d = (cnt_q == CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/ext_mem_bridge.sv
// Turns single core memory requests into SETUP / ACCESS / HOLD / DONE cycles
// on an asynchronous SRAM, stalling the core until core_ready.
module ext_mem_bridge
  import ext_mem_bridge_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  ext_mem_bridge_if.slave bus
);

  localparam int WAIT_EFF = (WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES;

  bridge_state_t     state_q;
  bridge_state_t     state_d;
  logic              rw_q;
  logic              rw_d;
  logic [15:0]       addr_q;
  logic [15:0]       addr_d;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] wdata_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;
  logic              ready_q;
  logic              ready_d;
  logic              busy_q;
  logic              busy_d;
  strobe_t           strobe_q;
  strobe_t           strobe_d;

  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_expired;

  assign cnt_load = (state_q == ST_SETUP);
  assign cnt_en   = (state_q == ST_ACCESS);

  mem_wait_counter #(
    .WAIT_CYCLES (WAIT_EFF)
  ) u_wait_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .en_i      (cnt_en),
    .expired_o (cnt_expired)
  );

  // Next state and the latched transaction fields.
  always_comb begin
    state_d = state_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.core_req) begin
          rw_d    = bus.core_rw;
          addr_d  = {bus.core_addr_h, bus.core_addr_l};
          wdata_d = bus.core_wdata;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (cnt_expired) begin
          if (rw_q == RW_READ) begin
            rdata_d = bus.ext_data_i;
            state_d = ST_DONE;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so every pin
  // reflects the state it belongs to without a combinational path.
  always_comb begin
    strobe_d = STROBE_IDLE;
    ready_d  = 1'b0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_SETUP: begin
        strobe_d.ce_n = STROBE_ON;
        if (rw_d == RW_READ) begin
          strobe_d.oe_n = STROBE_ON;
        end else begin
          strobe_d.data_oe = 1'b1;
        end
      end
      ST_ACCESS: begin
        strobe_d.ce_n = STROBE_ON;
        if (rw_d == RW_READ) begin
          strobe_d.oe_n = STROBE_ON;
        end else begin
          strobe_d.we_n    = STROBE_ON;
          strobe_d.data_oe = 1'b1;
        end
      end
      ST_HOLD: begin
        // we_n already released; address and data stay driven one more cycle.
        strobe_d.ce_n    = STROBE_ON;
        strobe_d.data_oe = 1'b1;
      end
      ST_DONE: begin
        ready_d = 1'b1;
      end
      default: begin
        strobe_d = STROBE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rw_q     <= RW_READ;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= STROBE_IDLE;
    end else begin
      state_q  <= state_d;
      rw_q     <= rw_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      strobe_q <= strobe_d;
    end
  end

  assign bus.core_rdata  = rdata_q;
  assign bus.core_ready  = ready_q;
  assign bus.busy        = busy_q;
  assign bus.ext_addr    = addr_q;
  assign bus.ext_data_o  = wdata_q;
  assign bus.ext_data_oe = strobe_q.data_oe;
  assign bus.ext_ce_n    = strobe_q.ce_n;
  assign bus.ext_oe_n    = strobe_q.oe_n;
  assign bus.ext_we_n    = strobe_q.we_n;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_ext_mem_bridge.sv
// Bench for ext_mem_bridge: two bridges (WAIT_CYCLES 2 and 0) share one SRAM
// model; a reference memory and expected-response queue check every completion.
module tb_ext_mem_bridge;
  import ext_mem_bridge_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring (index 0: WAIT=2, index 1: WAIT=0) --------
  logic [1:0] req_v, rw_v, ready_v, busy_v, doe_v, ce_v, oe_v, we_v;
  logic [7:0] ah_v [2];
  logic [7:0] al_v [2];
  logic [7:0] wd_v [2];
  logic [7:0] rd_v [2];
  logic [7:0] dout_v [2];
  logic [7:0] din_v [2];
  logic [15:0] ea_v [2];

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    ext_mem_bridge_if #(.DATA_W(8)) bus ();
    assign bus.core_req    = req_v[g];
    assign bus.core_rw     = rw_v[g];
    assign bus.core_addr_h = ah_v[g];
    assign bus.core_addr_l = al_v[g];
    assign bus.core_wdata  = wd_v[g];
    assign bus.ext_data_i  = din_v[g];
    assign rd_v[g]    = bus.core_rdata;
    assign ready_v[g] = bus.core_ready;
    assign busy_v[g]  = bus.busy;
    assign ea_v[g]    = bus.ext_addr;
    assign dout_v[g]  = bus.ext_data_o;
    assign doe_v[g]   = bus.ext_data_oe;
    assign ce_v[g]    = bus.ext_ce_n;
    assign oe_v[g]    = bus.ext_oe_n;
    assign we_v[g]    = bus.ext_we_n;

    ext_mem_bridge #(
      .WAIT_CYCLES ((g == 0) ? 2 : 0),
      .DATA_W      (8)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
    );
  end

  // ---------------- SRAM pad model ----------------
  logic [7:0] sram [logic [15:0]];

  function automatic logic [7:0] sram_rd(input logic [15:0] a);
    return sram.exists(a) ? sram[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (ce_v[g] === 1'b0 && we_v[g] === 1'b0) sram[ea_v[g]] = dout_v[g];
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      din_v[g] = (ce_v[g] === 1'b0 && oe_v[g] === 1'b0) ? sram_rd(ea_v[g]) : 8'h00;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] ref_mem [logic [15:0]];
  logic [7:0] last_rd [2];

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic        dut;
    logic        rw;
    logic [7:0]  data;
    logic [31:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int contention_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no event expected event within bound", name);
  endtask

  // Monitor: pops one expectation per core_ready pulse.
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (doe_v[g] === 1'b1 && oe_v[g] === 1'b0) contention_cnt++;
      if (rst_n && ready_v[g] === 1'b1) begin
        if (exp_q.size() == 0) begin
          fail_evt("unexpected_ready");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("ready_dut", 32'(g), 32'(e.dut));
          chk("ready_cycle", cyc, e.cyc);
          chk("core_rdata", rd_v[g], e.data);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_access(input int g, input logic rw, input logic [15:0] addr,
                           input logic [7:0] wd, input bit keep, input bit prof,
                           input bit scramble);
    int wt, n, i, to;
    int unsigned c0;
    logic [31:0] m_ce, m_oe, m_we, m_doe;
    logic [15:0] a_setup;
    logic [7:0]  d_setup;
    exp_t e;
    wt = (g == 0) ? 2 : 0;
    n  = (rw == RW_READ) ? wt + 3 : wt + 4;
    @(negedge clk);
    to = 0;
    while (busy_v[g] !== 1'b0 && to < 50) begin
      @(negedge clk);
      to++;
    end
    if (busy_v[g] !== 1'b0) begin
      fail_evt("idle_wait");
      return;
    end
    req_v[g] = 1'b1;
    rw_v[g]  = rw;
    ah_v[g]  = addr[15:8];
    al_v[g]  = addr[7:0];
    wd_v[g]  = wd;
    c0 = cyc;
    if (rw == RW_WRITE) ref_mem[addr] = wd;
    else last_rd[g] = ref_rd(addr);
    e.dut  = 1'(g);
    e.rw   = rw;
    e.data = last_rd[g];
    e.cyc  = c0 + 32'(n);
    exp_q.push_back(e);
    m_ce = '0; m_oe = '0; m_we = '0; m_doe = '0;
    a_setup = '0; d_setup = '0;
    i = 0;
    do begin
      @(negedge clk);
      i++;
      if (i == 1) begin
        a_setup = ea_v[g];
        d_setup = dout_v[g];
        if (scramble) begin
          ah_v[g] = 8'($urandom);
          al_v[g] = 8'($urandom);
          wd_v[g] = 8'($urandom);
        end
      end
      if (i < 32) begin
        m_ce[i]  = (ce_v[g] === 1'b0);
        m_oe[i]  = (oe_v[g] === 1'b0);
        m_we[i]  = (we_v[g] === 1'b0);
        m_doe[i] = (doe_v[g] === 1'b1);
      end
    end while (ready_v[g] !== 1'b1 && i < 40);
    if (ready_v[g] !== 1'b1) fail_evt("ready_timeout");
    if (!keep) req_v[g] = 1'b0;
    if (prof) begin
      chk("addr_in_setup", 32'(a_setup), 32'(addr));
      if (rw == RW_READ) begin
        chk("oe_profile", m_oe, span(1, wt + 2));
        chk("ce_profile", m_ce, span(1, wt + 2));
        chk("we_profile", m_we, 32'h0);
        chk("doe_profile", m_doe, 32'h0);
      end else begin
        chk("ce_profile", m_ce, span(1, wt + 3));
        chk("we_profile", m_we, span(2, wt + 2));
        chk("doe_profile", m_doe, span(1, wt + 3));
        chk("oe_profile", m_oe, 32'h0);
        chk("data_in_setup", 32'(d_setup), 32'(wd));
      end
    end
  endtask

  task automatic reset_mid_write();
    int to;
    @(negedge clk);
    to = 0;
    while (busy_v[0] !== 1'b0 && to < 50) begin
      @(negedge clk);
      to++;
    end
    req_v[0] = 1'b1;
    rw_v[0]  = RW_WRITE;
    ah_v[0]  = 8'h44;
    al_v[0]  = 8'h44;
    wd_v[0]  = 8'h77;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (we_v[0] !== 1'b0 && to < 20);
    if (we_v[0] !== 1'b0) fail_evt("we_low_wait");
    rst_n = 1'b0;
    req_v[0] = 1'b0;
    #1;
    chk("rst_strobes", 32'({ce_v[0], oe_v[0], we_v[0]}), 32'h7);
    chk("rst_data_oe", 32'(doe_v[0]), 32'h0);
    chk("rst_busy", 32'(busy_v[0]), 32'h0);
    chk("rst_ready", 32'(ready_v[0]), 32'h0);
    chk("rst_rdata", 32'(rd_v[0]), 32'h0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_mem", 32'(sram_rd(16'h4444)), 32'(ref_rd(16'h4444)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        rw;
    logic [15:0] addr;
    int          g;
    req_v = '0;
    rw_v  = '1;
    for (int k = 0; k < 2; k++) begin
      ah_v[k] = '0; al_v[k] = '0; wd_v[k] = '0; last_rd[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", 32'(rd_v[k]), 32'h0);
      chk("reset_ready_busy", 32'({ready_v[k], busy_v[k]}), 32'h0);
      chk("reset_addr", 32'(ea_v[k]), 32'h0);
      chk("reset_pad", 32'({dout_v[k], doe_v[k]}), 32'h0);
      chk("reset_strobes", 32'({ce_v[k], oe_v[k], we_v[k]}), 32'h7);
    end
    chk("reset_state0", 32'(gen_dut[0].bus.dbg_state), 32'(ST_IDLE));
    chk("reset_state1", 32'(gen_dut[1].bus.dbg_state), 32'(ST_IDLE));

    // preload through the fast bridge
    do_access(1, RW_WRITE, 16'h12F0, 8'hA5, 0, 0, 0);
    do_access(1, RW_WRITE, 16'hFFFF, 8'h81, 0, 0, 0);

    do_access(0, RW_READ, 16'h12F0, 8'h00, 0, 1, 0);
    do_access(0, RW_WRITE, 16'h0200, 8'h3C, 0, 1, 0);
    chk("sram_0200", 32'(sram_rd(16'h0200)), 32'h3C);

    do_access(1, RW_READ, 16'hFFFF, 8'h00, 0, 1, 0);
    do_access(1, RW_WRITE, 16'h0000, 8'h00, 0, 1, 0);

    // request held high across three reads
    do_access(0, RW_READ, 16'h0200, 8'h00, 1, 0, 0);
    do_access(0, RW_READ, 16'h12F0, 8'h00, 1, 0, 0);
    do_access(0, RW_READ, 16'hFFFF, 8'h00, 0, 0, 0);

    do_access(0, RW_WRITE, 16'h1234, 8'h55, 0, 1, 1);
    chk("sram_1234", 32'(sram_rd(16'h1234)), 32'h55);
    do_access(0, RW_READ, 16'h1234, 8'h00, 0, 0, 0);

    reset_mid_write();

    for (int t = 0; t < 60; t++) begin
      g    = int'($urandom_range(0, 1));
      rw   = 1'($urandom_range(0, 1));
      addr = {8'h3A, 4'h0, 4'($urandom_range(0, 15))};
      do_access(g, rw, addr, 8'($urandom), 0, ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 1));
    end

    repeat (5) @(negedge clk);
    chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
    chk("no_contention", 32'(contention_cnt), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    fail_evt("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ext_mem_bridge.md
Name: ext_mem_bridge

Overview:
- Sits directly downstream of the CPU datapath's memory buses. It turns the core's {memory_bus_h, memory_bus_l} address, data and mem_rw into timed cycles on an external asynchronous SRAM.
- The SRAM uses active-low chip-enable, output-enable and write-enable.
- Each access has setup, a programmable wait phase and hold. The bridge stalls the core via core_ready, so the control FSM can replace testmemory with real external memory.

Parameters:
- WAIT_CYCLES, 2, extra access-phase cycles beyond the minimum 1 (legal 0..15).
- DATA_W, 8, data width.

Ports:
- clk  in  1  system clock, same clock as the control FSM.
- rst_n  in  1  asynchronous active-low reset.
- core_req  in  1  access request, sampled only in IDLE.
- core_rw  in  1  1 = read, 0 = write (mem_rw polarity).
- core_addr_h  in  8  address high byte.
- core_addr_l  in  8  address low byte.
- core_wdata  in  DATA_W  write data.
- core_rdata  out  DATA_W  last read data; held until the next read completes.
- core_ready  out  1  one-cycle completion pulse.
- busy  out  1  high in any state other than IDLE.
- ext_addr  out  16  registered SRAM address.
- ext_data_o  out  DATA_W  write data to the pad.
- ext_data_oe  out  1  pad output enable.
- ext_data_i  in  DATA_W  read data from the pad.
- ext_ce_n  out  1  chip enable, active low.
- ext_oe_n  out  1  output enable, active low.
- ext_we_n  out  1  write enable, active low.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (rst_n).
- Reset values:
  - state = IDLE.
  - core_rdata = 0, core_ready = 0, busy = 0.
  - ext_addr = 0, ext_data_o = 0, ext_data_oe = 0.
  - ext_ce_n = ext_oe_n = ext_we_n = 1.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, SETUP, ACCESS, HOLD, DONE (shared enum). Any illegal encoding goes to IDLE on the next edge.
- IDLE:
  - On core_req = 1, latch address, rw and wdata, then go to SETUP.
  - Otherwise stay; all strobes are inactive.
- SETUP (1 cycle):
  - ext_ce_n = 0 and ext_addr valid.
  - Read: ext_oe_n = 0.
  - Write: ext_data_oe = 1 with ext_data_o = latched wdata; ext_we_n stays 1.
- ACCESS (WAIT_CYCLES+1 cycles, counted by the wait counter):
  - Read: ext_oe_n stays 0. ext_data_i is captured into core_rdata on the edge that ends the last ACCESS cycle; then go to DONE.
  - Write: ext_we_n = 0 throughout; then go to HOLD.
- HOLD (write only, 1 cycle):
  - ext_we_n = 1; address and data stay driven; ext_ce_n = 0.
  - Then go to DONE.
- DONE (1 cycle):
  - core_ready = 1; all strobes inactive; ext_data_oe = 0.
  - Always returns to IDLE. core_req is not sampled in DONE.
- Latency (req sampled at edge 0, core_ready high during cycle N):
  - Read: N = WAIT_CYCLES + 3.
  - Write: N = WAIT_CYCLES + 4.
  - Minimum request-to-request spacing is one full transaction plus one IDLE cycle.
- Invariants:
  - ext_data_oe = 1 and ext_oe_n = 0 are never true in the same cycle.
  - ext_we_n falls only after a full SETUP cycle with stable address and data, and rises one cycle before the data/address release.
- Requests: core_req while busy is ignored (no queue). The core must hold core_req until core_ready.
- Latching: address, rw and wdata are latched once at accept. Input changes mid-transaction have no effect.
- Counter: the wait counter reloads on SETUP→ACCESS entry. WAIT_CYCLES = 0 gives a single ACCESS cycle.
- Reset mid-transaction: immediate asynchronous return to reset values. Strobes deassert and the pad is released with no clock edge needed. core_rdata resets to 0.

Decomposition:
- Package ext_mem_bridge_pkg:
  - state enum bridge_state_t.
  - constants RW_READ = 1, RW_WRITE = 0.
  - strobe active-level constants.
  - WAIT_MAX = 15.
- One sub-module, mem_wait_counter: loadable down-counter with load, enable and a registered expired flag. Width is sized from WAIT_CYCLES (minimum 1 bit).

Test Plan:
- Read, WAIT_CYCLES = 2, addr 0x12F0, SRAM returns 0xA5 →
  - ext_oe_n low in cycles 1–4.
  - core_ready in cycle 5 only.
  - core_rdata = 0xA5, held through the next write.
- Write 0x3C to 0x0200, WAIT_CYCLES = 2 →
  - ext_we_n low exactly cycles 2–4.
  - ext_data_oe high cycles 1–5.
  - core_ready in cycle 6.
  - SRAM model holds 0x3C at 0x0200.
- WAIT_CYCLES = 0, read 0xFFFF →
  - ready in cycle 3.
  - Then write 0x00 to 0x0000 → ready 4 cycles after accept.
- core_req held continuously for 3 reads →
  - each accepted only from IDLE, one IDLE gap between them.
  - core_ready pulses are single cycles, 6 cycles apart (WAIT_CYCLES = 2).
- rst_n asserted in the ACCESS cycle of a write →
  - ext_we_n, ext_ce_n and ext_oe_n go to 1 and ext_data_oe to 0 before the next edge.
  - busy = 0; no core_ready pulse.
  - SRAM model contents unchanged or partial write flagged.
- Address/wdata changed during SETUP of a write to 0x1234 = 0x55 → SRAM writes 0x55 at 0x1234, and the bus-contention assertion never fires.
